rr_replay_unpacker: RTL
=======================

RR_REPLAY_UNPACKER -- requirements
Module: rr_replay_unpacker

Interface
REQ-001 SHALL have parameter AXI_WIDTH, default 512: width in bits of each storage word read back from the trace buffer.
REQ-002 SHALL have parameter LOGB_CHANNEL_CNT, default 2: number of logb channels; bits [LOGB_CHANNEL_CNT-1:0] of a unit form the valid bitmap.
REQ-003 SHALL have parameter LOGE_CHANNEL_CNT, default 1: number of loge valid bits following the logb bitmap.
REQ-004 SHALL have parameter CHANNEL_WIDTHS, default {8,16}: per-logb-channel payload width, indexed by channel.
REQ-005 SHALL derive FULL_WIDTH = sum(CHANNEL_WIDTHS) + LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT and OFFSET_WIDTH = $clog2(FULL_WIDTH+1); elaboration SHALL fail if FULL_WIDTH > AXI_WIDTH.
REQ-006 Ports, in order:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches cfg_total_bits and begins unpacking.
- cfg_total_bits  in  64  number of valid trace bits in the buffer (excludes padding).
- in_valid  in  1  storage word valid.
- in_ready  out  1  word accepted when in_valid & in_ready.
- in_data  in  AXI_WIDTH  storage word; bit 0 is the earliest trace bit.
- out_valid  out  1  replay unit valid.
- out_ready  in  1  replay unit consumed when out_valid & out_ready.
- out_data  out  FULL_WIDTH  unit, LSB-aligned; bits at and above out_len read 0.
- out_len  out  OFFSET_WIDTH  decoded unit length in bits.
- busy  out  1  high in RUN.
- done  out  1  sticky; set on normal completion.
- error  out  1  sticky; set on truncated unit.

Function
REQ-007 SHALL implement states IDLE, RUN and DONE; reset enters IDLE.
REQ-008 IDLE->RUN on start: clear the bit buffer, set fill=0, set remaining=cfg_total_bits, clear done and error. start outside IDLE SHALL be ignored.
REQ-009 SHALL keep a bit buffer of BUF_W = 2*AXI_WIDTH bits with a fill count (0..BUF_W); buffer bit 0 is the next unconsumed trace bit.
REQ-010 in_ready SHALL be 1 only in RUN with fill <= AXI_WIDTH, computed from registers only; an accepted word SHALL be appended at bit position fill.
REQ-011 Decode: len = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT + sum of CHANNEL_WIDTHS[i] for each set bitmap bit i; the adder SHALL be combinational from buffer bits.
REQ-012 out_valid SHALL be 1 only in RUN with remaining > 0, fill >= LOGB_CHANNEL_CNT, fill >= len and len <= remaining; out_valid SHALL NOT depend on out_ready.
REQ-013 out_data and out_len SHALL hold stable while out_valid & !out_ready.
REQ-014 On an output handshake, the buffer SHALL shift right by len, fill SHALL decrease by len and remaining SHALL decrease by len.
REQ-015 On a simultaneous input and output handshake in the same cycle, the new word SHALL be placed at position fill-len and fill SHALL become fill - len + AXI_WIDTH.
REQ-016 A unit straddling a word boundary SHALL be emitted whole once its last bit arrives; no bubble SHALL be inserted beyond the input wait.
REQ-017 When remaining reaches 0: go to DONE, set done, and drop all buffered padding bits. Further input words SHALL NOT be accepted.
REQ-018 If fill >= LOGB_CHANNEL_CNT and remaining > 0 but len > remaining: set error, go to DONE, and emit no unit. done SHALL stay 0.
REQ-019 Sustained throughput SHALL be one unit per cycle while buffered data suffices.

Reset
REQ-020 A synchronous rst, including mid-RUN, SHALL on the next edge force IDLE, fill=0, remaining=0, and in_ready=out_valid=busy=done=error=0; buffered bits SHALL be discarded.
REQ-021 out_data and out_len SHALL read 0 while out_valid=0 after reset.

Verification
(AXI_WIDTH=32, CHANNEL_WIDTHS {ch0=16, ch1=8}, LOGE=1, FULL_WIDTH=27; unit lengths: bitmap 11 -> 27, 01 -> 19, 10 -> 11, 00 -> 3.)
REQ-022 Start with total=27 and one word holding an 11-unit, out_ready=1 -> one unit, out_len=27, payload exact, done=1, in_ready=0.
REQ-023 Units 27,19 (total=46) across two words, second word delayed 5 cycles -> the 19-bit unit is emitted only after the second word arrives, with correct straddled data.
REQ-024 Ten 00-units (total=30) in one word, out_ready held low 3 cycles -> out_data/out_len stable, then 10 consecutive one-per-cycle outputs of len 3.
REQ-025 total=20 with the first unit bitmap 11 -> error=1, done=0, out_valid never 1.
REQ-026 rst asserted mid-RUN with fill=40 -> next cycle IDLE, all outputs 0; a new start with total=3 emits a single len-3 unit.
REQ-027 Random stream with random in_valid/out_ready, checked against a scoreboard -> every unit, length and order matches, done is set at exactly total bits.

Source files
------------

// File: rtl/rr_replay_unpacker.sv
// Replay-side unpacker: turns a stream of storage words back into variable-length
// trace units (logb bitmap + loge bits + payloads of the channels whose bitmap bit is set).

package rr_replay_unpacker_pkg;
  localparam int unsigned MAX_CHANNELS = 64;
  localparam int unsigned WIDTHS_BITS  = MAX_CHANNELS * 32;

  function automatic int unsigned sum_widths(input logic [WIDTHS_BITS-1:0] widths,
                                             input int unsigned count);
    int unsigned s;
    s = 0;
    for (int unsigned i = 0; i < MAX_CHANNELS; i++) begin
      if (i < count) s += widths[i*32 +: 32];
    end
    return s;
  endfunction
endpackage

module rr_replay_unpacker #(
  parameter int unsigned AXI_WIDTH        = 512,
  parameter int unsigned LOGB_CHANNEL_CNT = 2,
  parameter int unsigned LOGE_CHANNEL_CNT = 1,
  parameter logic [LOGB_CHANNEL_CNT-1:0][31:0] CHANNEL_WIDTHS = {32'd8, 32'd16},
  localparam int unsigned FULL_WIDTH =
    rr_replay_unpacker_pkg::sum_widths(2048'(CHANNEL_WIDTHS), LOGB_CHANNEL_CNT)
    + LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT,
  localparam int unsigned OFFSET_WIDTH = $clog2(FULL_WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [63:0]             cfg_total_bits,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [AXI_WIDTH-1:0]    in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FULL_WIDTH-1:0]   out_data,
  output logic [OFFSET_WIDTH-1:0] out_len,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int unsigned HDR_W  = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT;
  localparam int unsigned BUF_W  = 2 * AXI_WIDTH;
  localparam int unsigned FILL_W = $clog2(BUF_W + 1);

  if (FULL_WIDTH > AXI_WIDTH) begin : g_width_check
    $error("rr_replay_unpacker: FULL_WIDTH exceeds AXI_WIDTH");
  end
  if (LOGB_CHANNEL_CNT > rr_replay_unpacker_pkg::MAX_CHANNELS) begin : g_chan_check
    $error("rr_replay_unpacker: too many logb channels");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d, buf_sh;
  logic [FILL_W-1:0]  fill_q, fill_d, fill_sh;
  logic [63:0]        rem_q, rem_d;
  logic               done_q, done_d, error_q, error_d;

  logic [OFFSET_WIDTH-1:0] len;
  logic [63:0]             len64;
  logic [FULL_WIDTH-1:0]   len_mask;
  logic                    hdr_ok, unit_ok, trunc, in_fire, out_fire;

  always_comb begin
    len = OFFSET_WIDTH'(HDR_W);
    for (int unsigned i = 0; i < LOGB_CHANNEL_CNT; i++) begin
      if (buf_q[i]) len = len + OFFSET_WIDTH'(CHANNEL_WIDTHS[i]);
    end
  end

  assign len64   = 64'(len);
  assign hdr_ok  = (state_q == S_RUN) && (rem_q != '0) &&
                   (fill_q >= FILL_W'(LOGB_CHANNEL_CNT));
  assign unit_ok = hdr_ok && (fill_q >= FILL_W'(len)) && (len64 <= rem_q);
  assign trunc   = hdr_ok && (len64 > rem_q);

  assign in_ready  = (state_q == S_RUN) && (fill_q <= FILL_W'(AXI_WIDTH)) && (rem_q != '0);
  assign out_valid = unit_ok;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    len_mask = '1;
    len_mask = ~(len_mask << len);
  end

  // The unit sits at buffer bit 0 until consumed, so these stay stable while stalled.
  assign out_data = out_valid ? (buf_q[FULL_WIDTH-1:0] & len_mask) : '0;
  assign out_len  = out_valid ? len : '0;
  assign busy     = (state_q == S_RUN);
  assign done     = done_q;
  assign error    = error_q;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    fill_d  = fill_q;
    rem_d   = rem_q;
    done_d  = done_q;
    error_d = error_q;
    buf_sh  = buf_q;
    fill_sh = fill_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          buf_d   = '0;
          fill_d  = '0;
          rem_d   = cfg_total_bits;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      S_RUN: begin
        if (rem_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          buf_d   = '0;
          fill_d  = '0;
        end else if (trunc) begin
          state_d = S_DONE;
          error_d = 1'b1;
          buf_d   = '0;
          fill_d  = '0;
        end else begin
          // Consume first, then append at the post-shift fill so both handshakes can coexist.
          if (out_fire) begin
            buf_sh  = buf_q >> len;
            fill_sh = fill_q - FILL_W'(len);
            rem_d   = rem_q - len64;
          end
          buf_d  = buf_sh;
          fill_d = fill_sh;
          if (in_fire) begin
            buf_d  = buf_sh | (BUF_W'(in_data) << fill_sh);
            fill_d = fill_sh + FILL_W'(AXI_WIDTH);
          end
          if (out_fire && (rem_q == len64)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            buf_d   = '0;
            fill_d  = '0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      fill_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

endmodule
